// File: rtl/capture_controller_pkg.sv
// Shared definitions for the capture controller.
//   state_t   : controller FSM states
//   DELAY_LSB : bit position of the delay count inside cfg_data
//   READ_LSB  : bit position of the read count inside cfg_data
//   CNT_W     : width of the delay/read counters
package capture_controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    DELAY  = 3'd2,
    READ   = 3'd3,
    RWAIT  = 3'd4,
    TX     = 3'd5
  } state_t;

  localparam int DELAY_LSB = 16;
  localparam int READ_LSB  = 0;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/capture_tx_slot.sv
// Single-entry holding register between memory read data and the
// transmit valid/ready interface.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : drop any held entry (abort path)
//   load     : capture din and mark the slot full
//   pop      : consumer accepted the entry; mark the slot empty
//   din      : incoming read data
//   full     : slot holds a valid entry (drives tx_tvalid)
//   dout     : held entry (drives tx_tdata); stable while full
module capture_tx_slot #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic [DW-1:0] dout
);

  // Slot occupancy and data; data only changes on load so it stays
  // stable for the whole time the entry waits for acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= {DW{1'b0}};
    end else if (clr) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/capture_controller.sv
// Capture controller: writes the qualified sample stream into sample
// memory while armed, keeps writing a programmed number of samples after
// the trigger, then reads a programmed number of samples back and streams
// them to the transmitter one per valid/ready handshake.
//   clk, rst           : clock, asynchronous active-high reset
//   wrSize, cfg_data   : config strobe/word ([31:16] delay, [15:0] read)
//   arm, run           : start sampling / trigger hit
//   sti_tvalid/tdata   : qualified sample stream
//   mem_wr/mem_wdata   : sample memory write port
//   mem_rd, mem_rvalid, mem_rdata : sample memory read port
//   tx_tvalid/tready/tdata : transmit stream
//   busy               : controller not idle
// Optional build macro CAPTURE_CONTROLLER_ABORT_EN adds an `abort` input
// that forces a return to IDLE from any state.
module capture_controller
  import capture_controller_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrSize,
  input  logic [31:0]   cfg_data,
  input  logic          arm,
  input  logic          run,
`ifdef CAPTURE_CONTROLLER_ABORT_EN
  input  logic          abort,
`endif
  input  logic          sti_tvalid,
  input  logic [DW-1:0] sti_tdata,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          tx_tvalid,
  input  logic          tx_tready,
  output logic [DW-1:0] tx_tdata,
  output logic          busy
);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   delay_count, read_count;
  logic            wr_nxt, rd_nxt;
  logic [DW-1:0]   wdata_nxt;
  logic            slot_load, slot_pop, slot_clr;

  // Config is only accepted while idle, so a capture in flight always
  // runs with the counts it was armed with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_count <= {CW{1'b0}};
      read_count  <= {CW{1'b0}};
    end else if (wrSize && (state == IDLE)) begin
      delay_count <= cfg_data[DELAY_LSB +: CW];
      read_count  <= cfg_data[READ_LSB +: CW];
    end
  end

  // State, counter and registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= {CW{1'b0}};
      mem_wr    <= 1'b0;
      mem_wdata <= {DW{1'b0}};
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_wr    <= wr_nxt;
      mem_wdata <= wdata_nxt;
      mem_rd    <= rd_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = 1'b0;
    wdata_nxt = mem_wdata;
    rd_nxt    = 1'b0;
    slot_load = 1'b0;
    slot_pop  = 1'b0;
    slot_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_nxt = SAMPLE;
          cnt_nxt   = {CW{1'b0}};
        end
      end
      SAMPLE: begin
        // The sample presented with run is still part of the capture.
        if (sti_tvalid) begin
          wr_nxt    = 1'b1;
          wdata_nxt = sti_tdata;
        end
        if (run) begin
          state_nxt = DELAY;
          cnt_nxt   = {CW{1'b0}};
        end
      end
      DELAY: begin
        // Compare happens before counting, so delay_count=0 exits at once
        // and the sample arriving in the exit cycle is dropped.
        if (cnt == delay_count) begin
          state_nxt = READ;
          cnt_nxt   = {CW{1'b0}};
        end else if (sti_tvalid) begin
          wr_nxt    = 1'b1;
          wdata_nxt = sti_tdata;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      READ: begin
        if (cnt == read_count) begin
          state_nxt = IDLE;
        end else begin
          rd_nxt    = 1'b1;
          state_nxt = RWAIT;
        end
      end
      RWAIT: begin
        if (mem_rvalid) begin
          slot_load = 1'b1;
          state_nxt = TX;
        end
      end
      TX: begin
        if (tx_tvalid && tx_tready) begin
          slot_pop  = 1'b1;
          cnt_nxt   = cnt + CW'(1);
          state_nxt = READ;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {CW{1'b0}};
      end
    endcase
`ifdef CAPTURE_CONTROLLER_ABORT_EN
    // Abort overrides everything decided above.
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = {CW{1'b0}};
      wr_nxt    = 1'b0;
      rd_nxt    = 1'b0;
      slot_load = 1'b0;
      slot_pop  = 1'b0;
      slot_clr  = 1'b1;
    end
`endif
  end

  capture_tx_slot #(.DW(DW)) u_tx_slot (
    .clk  (clk),
    .rst  (rst),
    .clr  (slot_clr),
    .load (slot_load),
    .pop  (slot_pop),
    .din  (mem_rdata),
    .full (tx_tvalid),
    .dout (tx_tdata)
  );

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller. A scoreboard holds the
// sample words that must be written to memory (derived from the capture
// rules: everything from arm up to and including the run sample, then the
// first delay_count post-trigger samples) and the words that must come out
// of the transmit port (exactly what the memory responder returns).
module tb_capture_controller;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrSize;
  logic [31:0]   cfg_data;
  logic          arm;
  logic          run;
  logic          sti_tvalid;
  logic [DW-1:0] sti_tdata;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          tx_tvalid;
  logic          tx_tready;
  logic [DW-1:0] tx_tdata;
  logic          busy;
`ifdef CAPTURE_CONTROLLER_ABORT_EN
  logic          abort;
`endif

  capture_controller #(.DW(DW), .CW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrSize     (wrSize),
    .cfg_data   (cfg_data),
    .arm        (arm),
    .run        (run),
`ifdef CAPTURE_CONTROLLER_ABORT_EN
    .abort      (abort),
`endif
    .sti_tvalid (sti_tvalid),
    .sti_tdata  (sti_tdata),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .tx_tvalid  (tx_tvalid),
    .tx_tready  (tx_tready),
    .tx_tdata   (tx_tdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] wr_exp[$];
  logic [DW-1:0] tx_exp[$];
  logic [DW-1:0] rd_q[$];
  int wr_seen = 0;
  int rd_seen = 0;
  int tx_seen = 0;
  int rd_lat  = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 2ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Capture rule: pre-trigger samples, the run sample, then the first `delay` post samples.
  function automatic int model_writes(input int n_pre, input logic [DW-1:0] pre_base,
                                      input logic [DW-1:0] run_val, input int n_post,
                                      input logic [DW-1:0] post_base, input int delay);
    int n = 0;
    for (int i = 0; i < n_pre; i++) begin wr_exp.push_back(pre_base + DW'(i)); n++; end
    wr_exp.push_back(run_val); n++;
    for (int i = 0; i < n_post && i < delay; i++) begin wr_exp.push_back(post_base + DW'(i)); n++; end
    return n;
  endfunction

  task automatic write_cfg(input logic [31:0] v);
    tick(); wrSize = 1'b1; cfg_data = v;
    tick(); wrSize = 1'b0;
  endtask

  task automatic drive_capture(input int n_pre, input logic [DW-1:0] pre_base,
                               input logic [DW-1:0] run_val, input int n_post,
                               input logic [DW-1:0] post_base,
                               input bit do_lock, input logic [31:0] lock_cfg);
    tick(); arm = 1'b1; sti_tvalid = 1'b0;
    tick(); arm = 1'b0;
    for (int i = 0; i < n_pre; i++) begin
      wrSize = (do_lock && i == 0);
      if (do_lock && i == 0) cfg_data = lock_cfg;
      sti_tvalid = 1'b1; sti_tdata = pre_base + DW'(i);
      tick();
    end
    wrSize = 1'b0;
    run = 1'b1; sti_tvalid = 1'b1; sti_tdata = run_val;
    tick();
    run = 1'b0;
    for (int i = 0; i < n_post; i++) begin
      sti_tvalid = 1'b1; sti_tdata = post_base + DW'(i);
      tick();
    end
    sti_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    check(name, 64'(busy), 64'd0);
  endtask

  // Memory responder: returns the next queued word rd_lat cycles after each mem_rd.
  int cd = 0;
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk); #2;
      mem_rvalid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD0BAD0;
        end
      end
      if (mem_rd === 1'b1 && rst === 1'b0) cd = rd_lat;
    end
  end

  // Compare process: memory writes and transmit beats against the scoreboard,
  // plus transmit stability while back-pressured.
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      hold_prev = 1'b0;
    end else begin
      if (mem_wr === 1'b1) begin
        wr_seen++;
        if (wr_exp.size() == 0) check("mem_wr_spurious", 64'(mem_wr), 64'd0);
        else check("mem_wdata", 64'(mem_wdata), 64'(wr_exp.pop_front()));
      end
      if (mem_rd === 1'b1) rd_seen++;
      if (hold_prev) begin
        check("tx_hold_valid", 64'(tx_tvalid), 64'd1);
        check("tx_hold_data", 64'(tx_tdata), 64'(hold_data));
      end
      if (tx_tvalid === 1'b1 && tx_tready === 1'b1) begin
        tx_seen++;
        if (tx_exp.size() == 0) check("tx_spurious", 64'(tx_tvalid), 64'd0);
        else check("tx_tdata", 64'(tx_tdata), 64'(tx_exp.pop_front()));
      end
      hold_prev = (tx_tvalid === 1'b1) && (tx_tready !== 1'b1);
      hold_data = tx_tdata;
    end
  end

  int w0, r0, t0, n, k;
  initial begin
    rst = 1'b1; wrSize = 1'b0; cfg_data = '0; arm = 1'b0; run = 1'b0;
    sti_tvalid = 1'b0; sti_tdata = '0; tx_tready = 1'b1;
`ifdef CAPTURE_CONTROLLER_ABORT_EN
    abort = 1'b0;
`endif
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_tx_tdata", 64'(tx_tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick(); rst = 1'b0;

    // delay=3, read=2: 5 pre + run(0xA5) + 3 of 5 post samples written.
    write_cfg(32'h0003_0002);
    w0 = wr_seen; r0 = rd_seen; t0 = tx_seen;
    n = model_writes(5, 32'h100, 32'hA5, 5, 32'h200, 3);
    check("model_wr_count", 64'(n), 64'd9);
    check("model_run_slot", 64'(wr_exp[5]), 64'hA5);
    check("model_first_post", 64'(wr_exp[6]), 64'h200);
    rd_lat = 2;
    rd_q.push_back(32'h1111_1111); tx_exp.push_back(32'h1111_1111);
    rd_q.push_back(32'h2222_2222); tx_exp.push_back(32'h2222_2222);
    drive_capture(5, 32'h100, 32'hA5, 5, 32'h200, 1'b0, 32'h0);
    wait_idle(60, "d3r2_idle");
    check("d3r2_writes", 64'(wr_seen - w0), 64'd9);
    check("d3r2_reads", 64'(rd_seen - r0), 64'd2);
    check("d3r2_beats", 64'(tx_seen - t0), 64'd2);

    // delay=0, read=0: only the run sample is written, no readout.
    write_cfg(32'h0000_0000);
    w0 = wr_seen; r0 = rd_seen; t0 = tx_seen;
    n = model_writes(0, 32'h0, 32'h77, 3, 32'h88, 0);
    check("model_d0_count", 64'(n), 64'd1);
    drive_capture(0, 32'h0, 32'h77, 3, 32'h88, 1'b0, 32'h0);
    check("d0r0_idle_3cyc", 64'(busy), 64'd0);
    check("d0r0_writes", 64'(wr_seen - w0), 64'd1);
    check("d0r0_reads", 64'(rd_seen - r0), 64'd0);

    // Backpressure, delay=1 read=1, read latency 4, tx_tready low 10 cycles.
    write_cfg(32'h0001_0001);
    w0 = wr_seen; r0 = rd_seen; t0 = tx_seen;
    tx_tready = 1'b0;
    rd_lat = 4;
    rd_q.push_back(32'hDEAD_BEEF); tx_exp.push_back(32'hDEAD_BEEF);
    n = model_writes(0, 32'h0, 32'h31, 2, 32'h32, 1);
    drive_capture(0, 32'h0, 32'h31, 2, 32'h32, 1'b0, 32'h0);
    k = 0;
    while (tx_tvalid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("bp_tx_valid_seen", 64'(tx_tvalid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", 64'(tx_tvalid), 64'd1);
      check("bp_data_held", 64'(tx_tdata), 64'hDEAD_BEEF);
      @(negedge clk);
    end
    tick(); tx_tready = 1'b1;
    wait_idle(20, "bp_idle");
    check("bp_beats", 64'(tx_seen - t0), 64'd1);
    check("bp_reads", 64'(rd_seen - r0), 64'd1);
    check("bp_writes", 64'(wr_seen - w0), 64'd2);

    // Config lockout: wrSize in SAMPLE must not change delay (stays 1).
    w0 = wr_seen; r0 = rd_seen;
    rd_lat = 2;
    rd_q.push_back(32'h4444_0001); tx_exp.push_back(32'h4444_0001);
    n = model_writes(2, 32'h40, 32'h41, 3, 32'h42, 1);
    drive_capture(2, 32'h40, 32'h41, 3, 32'h42, 1'b1, 32'h0005_0000);
    wait_idle(30, "lock_idle");
    check("lock_writes", 64'(wr_seen - w0), 64'd4);
    check("lock_reads", 64'(rd_seen - r0), 64'd1);

    // Reset while a beat is held in TX, then a normal capture.
    write_cfg(32'h0000_0001);
    tx_tready = 1'b0;
    rd_q.push_back(32'hCAFE_0001); tx_exp.push_back(32'hCAFE_0001);
    n = model_writes(0, 32'h0, 32'h51, 0, 32'h0, 0);
    drive_capture(0, 32'h0, 32'h51, 0, 32'h0, 1'b0, 32'h0);
    k = 0;
    while (tx_tvalid !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    check("mid_tx_valid", 64'(tx_tvalid), 64'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    check("mid_rst_tx_tdata", 64'(tx_tdata), 64'd0);
    check("mid_rst_mem_wr", 64'(mem_wr), 64'd0);
    check("mid_rst_mem_rd", 64'(mem_rd), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    tx_exp.delete();
    tick(); rst = 1'b0; tx_tready = 1'b1;
    write_cfg(32'h0000_0001);
    t0 = tx_seen;
    rd_q.push_back(32'h0000_600D); tx_exp.push_back(32'h0000_600D);
    n = model_writes(0, 32'h0, 32'h52, 0, 32'h0, 0);
    drive_capture(0, 32'h0, 32'h52, 0, 32'h0, 1'b0, 32'h0);
    wait_idle(30, "resume_idle");
    check("resume_beats", 64'(tx_seen - t0), 64'd1);

`ifdef CAPTURE_CONTROLLER_ABORT_EN
    // Abort while in DELAY: idle next cycle, no readout.
    write_cfg(32'h0005_0002);
    r0 = rd_seen;
    n = model_writes(0, 32'h0, 32'h61, 2, 32'h62, 5);
    drive_capture(0, 32'h0, 32'h61, 2, 32'h62, 1'b0, 32'h0);
    @(negedge clk);
    check("abort_pre_busy", 64'(busy), 64'd1);
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check("abort_no_reads", 64'(rd_seen - r0), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("wr_queue_drained", 64'(wr_exp.size()), 64'd0);
    check("tx_queue_drained", 64'(tx_exp.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
- Sits directly downstream of the trigger block; consumes its `run` output together with the same qualified sample stream.
- Writes samples into sample memory while armed, then counts a programmed number of post-trigger samples.
- Then reads a programmed number of samples back from memory and streams them to the transmitter, one per handshake.
- Returns to idle when the readout completes.

Parameters:
- DW, 32, sample data width (matches trigger DW).
- CW, 16, width of delay and read counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wrSize  in  1  config strobe; latch cfg_data into count registers.
- cfg_data  in  32  config word; [31:16] delay_count, [15:0] read_count.
- arm  in  1  start sampling (pulse).
- run  in  1  trigger hit from trigger block.
- sti_tvalid  in  1  qualified sample valid.
- sti_tdata  in  DW  sample data.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DW  memory write data.
- mem_rd  out  1  memory read request (1-cycle pulse).
- mem_rvalid  in  1  read data valid (arbitrary latency ≥1).
- mem_rdata  in  DW  read data.
- tx_tvalid  out  1  transmit sample valid.
- tx_tready  in  1  transmitter accepts sample.
- tx_tdata  out  DW  transmit sample.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async): state=IDLE, cnt=0, delay_count=0, read_count=0.
  - Outputs: mem_wr=0, mem_wdata=0, mem_rd=0, tx_tvalid=0, tx_tdata=0, busy=0.
- Config:
  - wrSize is accepted only in IDLE; ignored otherwise.
  - Latched values take effect from the next arm.
- Counter width: CW bits, unsigned; compares are equality; no wrap is reachable (cnt ≤ programmed value).
- All outputs are registered; mem_wr/mem_wdata appear 1 cycle after the accepted sti sample.
- FSM:
  - IDLE:
    - arm=1 -> SAMPLE, cnt=0.
    - run is ignored.
  - SAMPLE:
    - Each cycle sti_tvalid=1 -> mem_wr=1, mem_wdata=sti_tdata.
    - run=1 -> DELAY, cnt=0. The sample in the run cycle, if valid, is still written.
    - arm is ignored.
  - DELAY:
    - If cnt==delay_count -> READ, cnt=0; the sample arriving in that cycle is not written.
    - Else, sti_tvalid=1 -> write the sample, cnt+=1.
    - delay_count=0 -> leave DELAY on the first DELAY cycle with zero extra writes.
  - READ:
    - If cnt==read_count -> IDLE (read_count=0 means no readout).
    - Else assert mem_rd for exactly 1 cycle -> RWAIT.
  - RWAIT:
    - On mem_rvalid: tx_tdata=mem_rdata, tx_tvalid=1 -> TX.
    - mem_rvalid outside RWAIT is ignored.
  - TX:
    - Hold tx_tvalid and tx_tdata stable until tx_tready.
    - On a handshake cycle: tx_tvalid=0, cnt+=1 -> READ.
- Handshake: tx_tdata must not change while tx_tvalid=1 and tx_tready=0.
- Simultaneous arm and wrSize in IDLE: config is latched and arm uses the NEW values.
- Simultaneous run and arm in IDLE: arm wins; run is ignored.
- mem_wr never asserts outside SAMPLE/DELAY; mem_rd never asserts outside READ.

Optional Feature:
- Macro: CAPTURE_CONTROLLER_ABORT_EN.
- Defined: adds input port `abort` (1 bit).
  - abort=1 in any state -> IDLE next cycle, cnt=0.
  - tx_tvalid, mem_wr and mem_rd are 0 from that cycle on.
  - abort has priority over all other transitions.
- Undefined: no `abort` port; the FSM exits only via normal completion or rst.

Decomposition:
- Package capture_controller_pkg holds:
  - state enum {IDLE, SAMPLE, DELAY, READ, RWAIT, TX};
  - cfg field constants DELAY_LSB=16, READ_LSB=0, CNT_W=16.
- One natural sub-module: capture_tx_slot. It is a single-entry holding register between mem_rdata and the tx valid/ready interface, with load/pop/full signals.

Test Plan:
- Reset mid-TX: assert rst while tx_tvalid=1 -> next edge all outputs 0, busy=0; wrSize then arm resumes normally.
- delay=3, read=2:
  - Stimulus: arm, 5 valid samples, run with a valid sample 0xA5, then 5 more valid samples.
  - Required: exactly 6+3=9 mem_wr pulses, then 2 mem_rd pulses, 2 tx beats, busy low after the last handshake.
- delay=0, read=0: arm, run -> no mem_wr after the run cycle, no mem_rd, back in IDLE within 3 cycles.
- Backpressure, read=1:
  - Stimulus: mem_rvalid returns 0xDEADBEEF 4 cycles after mem_rd; tx_tready held low 10 cycles.
  - Required: tx_tdata stable at 0xDEADBEEF with tx_tvalid=1 for all 10 cycles, exactly one beat accepted.
- Config lockout: wrSize with delay=0x00050000 while in SAMPLE -> ignored; the capture uses the previous delay.
- CAPTURE_CONTROLLER_ABORT_EN build: abort in DELAY -> IDLE the next cycle, zero mem_rd pulses.
